atm_keypad_frontend: RTL
========================

// Module: atm_keypad_frontend
// PURPOSE
// - User-side driver for ATM_controller: turns raw keypad/card events into the controller's input protocol
//   (tarjeta_recibida, tipo_trans, digito/digito_stb, monto/monto_stb) and tracks the controller's result outputs.
// - Sits between keypad/card-reader logic and ATM_controller; its port names match the controller's inputs one-to-one.
// - Also usable as a synthesizable stimulus source in place of tester.
// PARAMETERS
// - PIN_DIGITS    4           digits forwarded per PIN attempt
// - PIN_WAIT      4           cycles to wait for pin_incorrecto/bloqueo after last PIN digit
// - MAX_AMOUNT    32'd999999  largest amount accepted
// - TIMEOUT_CYC   1024        inactivity limit (used only with ATM_TIMEOUT_EN)
// PORTS
// - clk                   in   1   rising-edge clock
// - rst                   in   1   asynchronous reset, active-low
// - card_in               in   1   level: card physically present
// - trans_sel             in   1   0=deposit, 1=withdrawal; sampled on card insertion
// - key_valid             in   1   one-cycle key press strobe
// - key_code              in   4   0-9 digit, 4'hA ENTER, 4'hB CLEAR, 4'hC CANCEL, others ignored
// - pin_incorrecto        in   1   from controller
// - bloqueo               in   1   from controller
// - balance_actualizado   in   1   from controller
// - entregar_dinero       in   1   from controller
// - fondos_insuficientes  in   1   from controller
// - tarjeta_recibida      out  1   to controller
// - tipo_trans            out  1   to controller
// - digito_stb            out  1   to controller, one-cycle pulse
// - digito                out  4   to controller, valid while digito_stb=1
// - monto_stb             out  1   to controller, one-cycle pulse
// - monto                 out  32  to controller, held stable from monto_stb to end of transaction
// - busy                  out  1   1 in every state except IDLE
// - amount_err            out  1   one-cycle pulse on amount overflow
// - txn_done              out  1   one-cycle pulse when a transaction completes
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; all outputs 0; digit counter, amount accumulator, timers cleared.
// - All outputs registered. digito_stb and monto_stb are asserted exactly 1 cycle after the causing key_valid.
// - IDLE: card_in=1 -> CARD; tarjeta_recibida<=1 and tipo_trans<=trans_sel, both held until return to IDLE.
// - CARD (1 cycle) -> PIN.
// - PIN: digit key -> digito<=key_code, digito_stb pulse, cnt++. cnt reaching PIN_DIGITS -> PIN_CHK.
//   CLEAR is ignored: digits already sent cannot be recalled. ENTER is ignored.
// - PIN_CHK: wait PIN_WAIT cycles; keys ignored.
//   - bloqueo=1 -> LOCKED.
//   - pin_incorrecto=1 -> PIN with cnt=0.
//   - bloqueo has priority when both are seen in the same cycle.
//   - Timer expiry with neither seen -> AMOUNT.
// - AMOUNT: digit -> acc = acc*10 + digit, computed 33 bits wide.
//   - Result > MAX_AMOUNT -> acc unchanged, amount_err pulse.
//   - CLEAR -> acc=0.
//   - ENTER -> monto<=acc, monto_stb pulse -> RESULT. ENTER with acc=0 is ignored.
// - RESULT: any of balance_actualizado, entregar_dinero, fondos_insuficientes -> txn_done pulse -> EJECT.
//   - Simultaneous results give a single txn_done.
// - LOCKED: no strobes issued; stays until card_in=0.
// - EJECT: stays until card_in=0.
// - Any state except IDLE:
//   - card_in=0 -> IDLE next cycle; tarjeta_recibida<=0; acc and cnt cleared.
//   - CANCEL key -> EJECT.
// - Strobe outputs never assert in the same cycle as a state change to IDLE.
// CONFIGURATION
// - ATM_TIMEOUT_EN defined:
//   - Per-state cycle counter, cleared on every key_valid and state change.
//   - Reaching TIMEOUT_CYC in PIN or AMOUNT -> EJECT.
//   - RESULT, PIN_CHK and LOCKED are exempt.
// - ATM_TIMEOUT_EN undefined: no counter logic; PIN and AMOUNT wait indefinitely.
// TESTING
// - Insert card, trans_sel=1, keys 1,2,3,4 -> tipo_trans=1; four digito_stb pulses with digito=1,2,3,4, each 1 cycle after its key.
// - PIN sent, pin_incorrecto in PIN_CHK -> back to PIN; next 4 digits forwarded again; third failure with bloqueo=1 -> LOCKED,
//   no further strobes; card_in=0 -> busy=0.
// - After PIN, keys 5,0,0,ENTER -> monto=500 with a single monto_stb pulse; entregar_dinero=1 -> txn_done pulse, then EJECT.
// - AMOUNT keys 9,9,9,9,9,9,9 -> 7th digit gives amount_err, acc stays 999999. CLEAR then 2,ENTER -> monto=2.
// - rst pulsed low mid-AMOUNT -> all outputs 0 immediately, state IDLE. ENTER with acc=0 -> no monto_stb.
// - With ATM_TIMEOUT_EN and TIMEOUT_CYC=16: no key for 16 cycles in PIN -> EJECT. Without the macro -> remains in PIN.

Source files
------------

// File: rtl/atm_keypad_frontend.sv
// Keypad/card front end for ATM_controller: turns key and card events into the controller's strobe protocol.
// Optional inactivity ejection is built only when ATM_TIMEOUT_EN is defined.
module atm_keypad_frontend #(
  parameter int          PIN_DIGITS  = 4,
  parameter int          PIN_WAIT    = 4,
  parameter logic [31:0] MAX_AMOUNT  = 32'd999999,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic        trans_sel,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        pin_incorrecto,
  input  logic        bloqueo,
  input  logic        balance_actualizado,
  input  logic        entregar_dinero,
  input  logic        fondos_insuficientes,
  output logic        tarjeta_recibida,
  output logic        tipo_trans,
  output logic        digito_stb,
  output logic [3:0]  digito,
  output logic        monto_stb,
  output logic [31:0] monto,
  output logic        busy,
  output logic        amount_err,
  output logic        txn_done
);

  localparam int CNT_W  = $clog2(PIN_DIGITS + 1);
  localparam int WAIT_W = (PIN_WAIT > 1) ? $clog2(PIN_WAIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PIN_DIGITS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PIN_WAIT - 1);

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE, S_CARD, S_PIN, S_PIN_CHK, S_AMOUNT, S_RESULT, S_LOCKED, S_EJECT
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [WAIT_W-1:0]   wait_cnt, wait_nx;
  logic [31:0]         acc, acc_nx;
  logic [32:0]         acc_cand;
  logic                tarj_nx, tipo_nx, dstb_nx, mstb_nx, aerr_nx, done_nx, busy_nx;
  logic [3:0]          digito_nx;
  logic [31:0]         monto_nx;
  logic                is_digit, is_enter, is_clear, is_cancel, any_result;
  logic                tmo_hit;

  // Decimal shift-in kept one bit wider so an overflow past MAX_AMOUNT is visible.
  function automatic logic [32:0] acc_step(input logic [31:0] a, input logic [3:0] d);
    acc_step = ({1'b0, a} * 33'd10) + {29'b0, d};
  endfunction

  assign is_digit   = key_valid && (key_code <= 4'd9);
  assign is_enter   = key_valid && (key_code == KEY_ENTER);
  assign is_clear   = key_valid && (key_code == KEY_CLEAR);
  assign is_cancel  = key_valid && (key_code == KEY_CANCEL);
  assign any_result = balance_actualizado | entregar_dinero | fondos_insuficientes;
  assign acc_cand   = acc_step(acc, key_code);

`ifdef ATM_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Idle counter restarts on any key or state change and saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (key_valid || (state_nx != state)) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST) && !key_valid &&
                   ((state == S_PIN) || (state == S_AMOUNT));
`else
  // No inactivity counter in this build; TIMEOUT_CYC only keeps the parameter list uniform.
  assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wait_nx   = wait_cnt;
    acc_nx    = acc;
    tarj_nx   = tarjeta_recibida;
    tipo_nx   = tipo_trans;
    digito_nx = digito;
    monto_nx  = monto;
    dstb_nx   = 1'b0;
    mstb_nx   = 1'b0;
    aerr_nx   = 1'b0;
    done_nx   = 1'b0;

    case (state)
      S_IDLE: begin
        if (card_in) begin
          state_nx = S_CARD;
          tarj_nx  = 1'b1;
          tipo_nx  = trans_sel;
        end
      end
      S_CARD: state_nx = S_PIN;
      S_PIN: begin
        if (is_digit) begin
          digito_nx = key_code;
          dstb_nx   = 1'b1;
          cnt_nx    = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            wait_nx  = '0;
            state_nx = S_PIN_CHK;
          end
        end
      end
      S_PIN_CHK: begin
        if (bloqueo) begin
          state_nx = S_LOCKED;
        end else if (pin_incorrecto) begin
          cnt_nx   = '0;
          state_nx = S_PIN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = S_AMOUNT;
        end else begin
          wait_nx = wait_cnt + WAIT_W'(1);
        end
      end
      S_AMOUNT: begin
        if (is_digit) begin
          if (acc_cand > {1'b0, MAX_AMOUNT}) aerr_nx = 1'b1;
          else                               acc_nx  = acc_cand[31:0];
        end else if (is_clear) begin
          acc_nx = '0;
        end else if (is_enter && (acc != '0)) begin
          monto_nx = acc;
          mstb_nx  = 1'b1;
          state_nx = S_RESULT;
        end
      end
      S_RESULT: begin
        if (any_result) begin
          done_nx  = 1'b1;
          state_nx = S_EJECT;
        end
      end
      S_LOCKED: state_nx = S_LOCKED;
      S_EJECT:  state_nx = S_EJECT;
      default:  state_nx = S_IDLE;
    endcase

    if (tmo_hit) state_nx = S_EJECT;

    // Card removal overrides everything, including strobes computed above.
    if (state != S_IDLE) begin
      if (is_cancel) state_nx = S_EJECT;
      if (!card_in) begin
        state_nx = S_IDLE;
        tarj_nx  = 1'b0;
        tipo_nx  = 1'b0;
        acc_nx   = '0;
        cnt_nx   = '0;
        wait_nx  = '0;
        monto_nx = '0;
        dstb_nx  = 1'b0;
        mstb_nx  = 1'b0;
        aerr_nx  = 1'b0;
        done_nx  = 1'b0;
      end
    end

    busy_nx = (state_nx != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      wait_cnt         <= '0;
      acc              <= '0;
      tarjeta_recibida <= 1'b0;
      tipo_trans       <= 1'b0;
      digito_stb       <= 1'b0;
      digito           <= '0;
      monto_stb        <= 1'b0;
      monto            <= '0;
      busy             <= 1'b0;
      amount_err       <= 1'b0;
      txn_done         <= 1'b0;
    end else begin
      state            <= state_nx;
      cnt              <= cnt_nx;
      wait_cnt         <= wait_nx;
      acc              <= acc_nx;
      tarjeta_recibida <= tarj_nx;
      tipo_trans       <= tipo_nx;
      digito_stb       <= dstb_nx;
      digito           <= digito_nx;
      monto_stb        <= mstb_nx;
      monto            <= monto_nx;
      busy             <= busy_nx;
      amount_err       <= aerr_nx;
      txn_done         <= done_nx;
    end
  end

endmodule
